// File: rtl/cpu_pkg.sv
// Shared definitions for the run sequencer.
// Provides the sequencer state encoding and the data-memory bus widths.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DONE,
        TMO
    } seq_state_t;

endpackage

// File: rtl/run_sequencer_edge_detect.sv
// Registered rising-edge detector.
// Ports:
//   clk   - clock, state on posedge
//   reset - synchronous active-high reset, clears the held level
//   din   - level input
//   rise  - high while din is 1 and the previous-cycle level was 0
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    // A level that was already high last cycle is not an edge.
    assign rise = din & ~din_q;

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: loads the init ROM into data memory, starts the core,
// and times the run until the core signals done or the watchdog expires.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   go           - run request, honoured in IDLE, DONE and TMO
//   rom_addr     - init ROM address (combinational read)
//   rom_data     - init ROM data, passed straight to mem_data during LOAD
//   mem_we/addr/data - data memory write port, active only in LOAD
//   cpu_start    - core start, high only in START
//   cpu_done     - core done level
//   busy         - high in LOAD, START and RUN
//   finished     - high while in DONE
//   timed_out    - high while in TMO
//   cycle_count  - RUN cycles of the last or current run (saturating)
module run_sequencer
    import cpu_pkg::*;
#(
    parameter int LOAD_LEN  = 256,
    parameter int START_LEN = 2,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_start,
    input  logic              cpu_done,
    output logic              busy,
    output logic              finished,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int SC_W = (START_LEN > 1) ? $clog2(START_LEN) : 1;

    // The load index is one bit wider than the address so a full 256-byte
    // load reaches its last index without wrapping.
    localparam logic [8:0]       LAST_IDX   = 9'(LOAD_LEN - 1);
    localparam logic [SC_W-1:0]  LAST_START = SC_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_CNT    = CNT_W'(TIMEOUT);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [8:0]       idx;
    logic [SC_W-1:0]  start_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             launch;
    logic             done_rise;

    edge_detect u_done_edge (
        .clk   (clk),
        .reset (reset),
        .din   (cpu_done),
        .rise  (done_rise)
    );

    assign cnt_next = (&cycle_count) ? cycle_count : cycle_count + 1'b1;

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        busy       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        rom_addr   = '0;
        cpu_start  = 1'b0;
        case (state)
            IDLE, DONE, TMO: begin
                if (go) begin
                    state_next = LOAD;
                    launch     = 1'b1;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                rom_addr = idx[ADDR_W-1:0];
                mem_addr = idx[ADDR_W-1:0];
                mem_data = rom_data;
                if (idx == LAST_IDX) begin
                    state_next = START;
                end
            end
            START: begin
                busy      = 1'b1;
                cpu_start = 1'b1;
                if (start_cnt == LAST_START) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // A done edge on the limit cycle takes priority over timeout.
                if (done_rise) begin
                    state_next = DONE;
                end else if (cnt_next == TMO_CNT) begin
                    state_next = TMO;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            start_cnt   <= '0;
            cycle_count <= '0;
            finished    <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            state     <= state_next;
            // Status flags track the terminal state they describe.
            finished  <= (state_next == DONE);
            timed_out <= (state_next == TMO);
            if (launch) begin
                idx         <= '0;
                start_cnt   <= '0;
                cycle_count <= '0;
            end
            case (state)
                LOAD: begin
                    idx       <= idx + 9'd1;
                    start_cnt <= '0;
                end
                START: begin
                    start_cnt <= start_cnt + 1'b1;
                end
                RUN: begin
                    cycle_count <= cnt_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

    localparam int LOAD_LEN  = 4;
    localparam int START_LEN = 2;
    localparam int CNT_W     = 16;
    localparam int TIMEOUT   = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             go;
    logic [7:0]       rom_addr;
    logic [7:0]       rom_data;
    logic             mem_we;
    logic [7:0]       mem_addr;
    logic [7:0]       mem_data;
    logic             cpu_start;
    logic             cpu_done;
    logic             busy;
    logic             finished;
    logic             timed_out;
    logic [CNT_W-1:0] cycle_count;

    logic [7:0] rom_mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr];

    run_sequencer #(
        .LOAD_LEN  (LOAD_LEN),
        .START_LEN (START_LEN),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .cpu_start   (cpu_start),
        .cpu_done    (cpu_done),
        .busy        (busy),
        .finished    (finished),
        .timed_out   (timed_out),
        .cycle_count (cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input bit fin, input bit tmo, input int cnt);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, ".cpu_start"}, 32'(cpu_start), 32'd0);
        chk({tag, ".finished"}, 32'(finished), 32'(fin));
        chk({tag, ".timed_out"}, 32'(timed_out), 32'(tmo));
        chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(cnt));
    endtask

    // Reference outcome of a run: the first fresh done edge at or before the
    // limit ends it as DONE after that many RUN cycles, otherwise it times out
    // after exactly TIMEOUT cycles.
    task automatic do_run(input int done_at, input bit stale, output bit exp_done, output int exp_len);
        if (!stale && done_at >= 1 && done_at <= TIMEOUT) begin
            exp_done = 1'b1;
            exp_len  = done_at;
        end else begin
            exp_done = 1'b0;
            exp_len  = TIMEOUT;
        end
        cpu_done = stale;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int k = 0; k < LOAD_LEN; k++) begin
            if (k == 0) begin
                chk("load.finished_clr", 32'(finished), 32'd0);
                chk("load.timed_out_clr", 32'(timed_out), 32'd0);
                chk("load.count_clr", 32'(cycle_count), 32'd0);
            end
            chk("load.mem_we", 32'(mem_we), 32'd1);
            chk("load.mem_addr", 32'(mem_addr), 32'(k));
            chk("load.mem_data", 32'(mem_data), 32'(rom_mem[k]));
            chk("load.busy", 32'(busy), 32'd1);
            chk("load.cpu_start", 32'(cpu_start), 32'd0);
            @(negedge clk);
        end
        for (int s = 0; s < START_LEN; s++) begin
            chk("start.cpu_start", 32'(cpu_start), 32'd1);
            chk("start.mem_we", 32'(mem_we), 32'd0);
            chk("start.busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        for (int r = 1; r <= exp_len; r++) begin
            chk("run.busy", 32'(busy), 32'd1);
            chk("run.cpu_start", 32'(cpu_start), 32'd0);
            chk("run.mem_we", 32'(mem_we), 32'd0);
            chk("run.cycle_count", 32'(cycle_count), 32'(r - 1));
            if (!stale && r == done_at) cpu_done = 1'b1;
            @(negedge clk);
        end
        check_quiet("end", exp_done, !exp_done, exp_len);
        // The terminal state holds regardless of cpu_done while go stays low.
        for (int h = 0; h < 3; h++) begin
            cpu_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_quiet("hold", exp_done, !exp_done, exp_len);
        end
    endtask

    initial begin
        bit fin_e;
        int len_e;

        reset    = 1'b1;
        go       = 1'b0;
        cpu_done = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i + 8'h10);

        repeat (3) begin
            @(negedge clk);
            check_quiet("reset", 1'b0, 1'b0, 0);
            chk("reset.rom_addr", 32'(rom_addr), 32'd0);
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_quiet("idle", 1'b0, 1'b0, 0);
        end

        // Normal completion on the 7th RUN cycle.
        do_run(7, 1'b0, fin_e, len_e);
        // Done level held from before go: never an edge, times out.
        do_run(0, 1'b1, fin_e, len_e);
        // Edge on the very cycle the limit is reached: DONE wins.
        do_run(TIMEOUT, 1'b0, fin_e, len_e);

        // Reset in the middle of LOAD, while writing address 2.
        cpu_done = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("midrst.addr0", 32'(mem_addr), 32'd0);
        @(negedge clk);
        chk("midrst.addr1", 32'(mem_addr), 32'd1);
        @(negedge clk);
        chk("midrst.addr2", 32'(mem_addr), 32'd2);
        chk("midrst.we2", 32'(mem_we), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("midrst.after", 1'b0, 1'b0, 0);
        reset = 1'b0;
        @(negedge clk);
        check_quiet("midrst.idle", 1'b0, 1'b0, 0);
        do_run(5, 1'b0, fin_e, len_e);

        // Randomized runs, chained back-to-back from DONE/TMO.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
            do_run(int'($urandom_range(1, TIMEOUT + 4)), 1'b0, fin_e, len_e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
